stream_mux_nto1: RTL and testbench
==================================

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (2..16).
REQ-002 Parameter WIDTH, default 8, data width per channel in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port list:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- s_valid  in  N_CH  per-channel beat valid
- s_ready  out  N_CH  per-channel beat accepted
- s_data  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- s_last  in  N_CH  per-channel end-of-packet
- sel  in  CW=max(1,$clog2(N_CH))  fixed-mode channel select
- rr_en  in  1  1 = round-robin mode, 0 = fixed select
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  WIDTH  output data
- m_last  out  1  output end-of-packet
- m_ch  out  CW  source channel of the current output beat

Function
REQ-005 Output register load_en SHALL be (!m_valid || m_ready).
REQ-006 s_ready SHALL be one-hot or zero, asserted only for the granted channel while load_en=1; s_ready is combinational.
REQ-007 A beat is accepted when s_valid[g] && s_ready[g]; data/last/channel SHALL appear on m_* the next cycle (latency 1).
REQ-008 While m_valid=1 && m_ready=0, m_data/m_last/m_ch SHALL be held stable.
REQ-009 The state machine SHALL have the states IDLE and LOCKED.
REQ-010 IDLE grant: rr_en=0 -> g=sel; rr_en=1 -> g = first channel with s_valid=1, searching cyclically from ptr+1.
REQ-011 In IDLE, a sel value >= N_CH SHALL produce no grant (all s_ready=0).
REQ-012 IDLE to LOCKED SHALL occur on an accepted beat with s_last=0; the lock channel is latched as g.
REQ-013 In LOCKED, only the lock channel SHALL be granted; changes on sel and rr_en SHALL be ignored.
REQ-014 LOCKED to IDLE SHALL occur on an accepted beat with s_last=1.
REQ-015 An accepted beat with s_last=1 in IDLE SHALL be a single-beat packet; the state stays IDLE.
REQ-016 ptr SHALL update to the granted channel only when a last beat is accepted, in either mode.
REQ-017 Mode changes SHALL take effect only at packet boundaries, i.e. in IDLE.
REQ-018 If no channel is valid, no beat is accepted; m_valid falls after the held beat drains.
REQ-019 With m_ready held at 1 and the granted channel streaming, throughput SHALL be one beat per cycle.

Reset
REQ-020 On rst=1 at a clock edge: m_valid=0, m_data=0, m_last=0, m_ch=0, state=IDLE, ptr=N_CH-1, so channel 0 has first round-robin priority.
REQ-021 Reset mid-packet SHALL drop the lock and discard any held output beat; s_ready SHALL be 0 during the reset cycle.

Structure
REQ-022 The shared package stream_mux_pkg SHALL hold the state encodings (IDLE=0, LOCKED=1) and the CW width function.
REQ-023 Sub-module rr_pick SHALL be a combinational rotating-priority picker: inputs req[N_CH] and ptr; outputs gnt index and any.

Verification (N_CH=4, WIDTH=8)
REQ-024 Fixed mode: rr_en=0, sel=2, ch2 sends 0x11,0x22 (last on 0x22), m_ready=1 -> m_data 0x11, 0x22 on consecutive cycles, m_ch=2, m_last on the second beat.
REQ-025 Round-robin: all four channels send single-beat packets continuously, m_ready=1 -> m_ch sequence 0,1,2,3,0.
REQ-026 Lock: ch1 starts a 3-beat packet, ch0 valid throughout, sel toggled mid-packet -> all three ch1 beats output contiguously before any ch0 beat.
REQ-027 Backpressure: m_ready=0 for 3 cycles with m_valid=1, m_data=0x5A -> m_data stays 0x5A, s_ready=0; on m_ready=1 the next beat is accepted in the same cycle.
REQ-028 Out-of-range and reset: sel=3 with N_CH=3 -> s_ready=0; rst pulsed mid-packet -> m_valid=0 next cycle, state IDLE, ch0 granted first.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 packet stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned cw_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester found searching cyclically from ptr+1.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned CW   = cw_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [CW-1:0]   gnt,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    idx = 0;
    gnt = '0;
    any = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = (32'(ptr) + i) % N_CH;
      if (!any && req[CW'(idx)]) begin
        gnt = CW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 packet stream multiplexer with fixed or round-robin selection,
// packet locking and a single registered output stage.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = cw_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       s_valid,
  output logic [N_CH-1:0]       s_ready,
  input  logic [N_CH*WIDTH-1:0] s_data,
  input  logic [N_CH-1:0]       s_last,
  input  logic [CW-1:0]         sel,
  input  logic                  rr_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic [CW-1:0]         m_ch
);

  state_t           state_q;
  logic [CW-1:0]    lock_q;
  logic [CW-1:0]    ptr_q;
  logic [CW-1:0]    pick_gnt;
  logic             pick_any;
  logic [CW-1:0]    g;
  logic             gv;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] g_data;
  logic             g_last;
  logic             g_valid;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req (s_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  assign load_en = !m_valid || m_ready;

  // Mode and select inputs only matter between packets.
  always_comb begin
    g  = '0;
    gv = 1'b0;
    if (state_q == LOCKED) begin
      g  = lock_q;
      gv = 1'b1;
    end else if (rr_en) begin
      g  = pick_gnt;
      gv = pick_any;
    end else begin
      g  = sel;
      gv = (32'(sel) < N_CH);
    end
  end

  always_comb begin
    g_data  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    s_ready = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (g == CW'(k)) begin
        g_data            = s_data[k*WIDTH +: WIDTH];
        g_last            = s_last[CW'(k)];
        g_valid           = s_valid[CW'(k)];
        s_ready[CW'(k)]   = gv && load_en && !rst;
      end
    end
  end

  assign accept = gv && load_en && g_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_ch    <= '0;
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= CW'(N_CH - 1);
    end else begin
      if (load_en) begin
        m_valid <= accept;
      end
      if (accept) begin
        m_data <= g_data;
        m_last <= g_last;
        m_ch   <= g;
        if (g_last) begin
          state_q <= IDLE;
          ptr_q   <= g;
        end else begin
          state_q <= LOCKED;
          lock_q  <= g;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1: directed scenarios plus a
// randomized run compared against a packet-level reference model.
module tb_stream_mux_nto1;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [1:0]  sel;
  logic        rr_en, m_valid, m_ready, m_last;
  logic [7:0]  m_data;
  logic [1:0]  m_ch;

  logic [2:0]  s_valid3, s_ready3, s_last3;
  logic [23:0] s_data3;
  logic [1:0]  sel3, m_ch3;
  logic        rr_en3, m_valid3, m_ready3, m_last3;
  logic [7:0]  m_data3;

  int checks = 0;
  int errors = 0;

  // Reference model state: output register, lock owner (-1 = none), last served channel.
  int mv, md, ml, mc, locked, last_ptr;

  always #5 clk = ~clk;

  stream_mux_nto1 #(.N_CH(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .sel(sel), .rr_en(rr_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_ch(m_ch)
  );

  stream_mux_nto1 #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .s_last(s_last3), .sel(sel3), .rr_en(rr_en3), .m_valid(m_valid3), .m_ready(m_ready3),
    .m_data(m_data3), .m_last(m_last3), .m_ch(m_ch3)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    s_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input int ch, input logic [7:0] d, input logic l);
    s_data[ch*8 +: 8] = d;
    s_last[ch] = l;
  endtask

  function automatic int exp_grant(input logic [3:0] v, input logic [1:0] s, input logic rr);
    if (locked >= 0) return locked;
    if (!rr) return (int'(s) < N) ? int'(s) : -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last_ptr + i) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; s_valid = '1; rr_en = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_s_ready got %b exp 0000", s_ready); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL reset_m_ch got %0d exp 0", m_ch); end
    rst = 1'b0; s_valid = '0; rr_en = 1'b0;
  endtask

  task automatic test_fixed();
    rr_en = 1'b0; sel = 2'd2; m_ready = 1'b1;
    s_valid = 4'b0100; drive(2, 8'h11, 1'b0);
    #1;
    checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b exp 0100", s_ready); end
    tick();
    checks++; if ({m_valid, m_data, m_ch, m_last} !== {1'b1, 8'h11, 2'd2, 1'b0})
      begin errors++; $display("FAIL fixed_beat0 got v%b d%h ch%0d l%b exp v1 d11 ch2 l0", m_valid, m_data, m_ch, m_last); end
    drive(2, 8'h22, 1'b1);
    tick();
    checks++; if ({m_valid, m_data, m_ch, m_last} !== {1'b1, 8'h22, 2'd2, 1'b1})
      begin errors++; $display("FAIL fixed_beat1 got v%b d%h ch%0d l%b exp v1 d22 ch2 l1", m_valid, m_data, m_ch, m_last); end
    s_valid = '0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got %b exp 0", m_valid); end
  endtask

  task automatic test_round_robin();
    int exp_ch[5];
    exp_ch = '{0, 1, 2, 3, 0};
    reset_pulse();
    rr_en = 1'b1; m_ready = 1'b1;
    s_valid = 4'hF; s_last = 4'hF; s_data = 32'hA3A2A1A0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_ch !== 2'(exp_ch[i]) || m_data !== 8'(8'hA0 + exp_ch[i]) || m_valid !== 1'b1)
        begin errors++; $display("FAIL rr_seq%0d got ch%0d d%h v%b exp ch%0d", i, m_ch, m_data, m_valid, exp_ch[i]); end
    end
    s_valid = '0;
    tick();
  endtask

  task automatic test_lock();
    reset_pulse();
    rr_en = 1'b0; sel = 2'd1; m_ready = 1'b1;
    s_valid = 4'b0010; drive(1, 8'hB1, 1'b0); drive(0, 8'hC0, 1'b1);
    tick();
    checks++; if (m_ch !== 2'd1 || m_data !== 8'hB1) begin errors++; $display("FAIL lock_b1 got ch%0d d%h exp ch1 dB1", m_ch, m_data); end
    s_valid = 4'b0011; sel = 2'd0; rr_en = 1'b1; drive(1, 8'hB2, 1'b0);
    #1;
    checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready got %b exp 0010", s_ready); end
    tick();
    checks++; if (m_ch !== 2'd1 || m_data !== 8'hB2) begin errors++; $display("FAIL lock_b2 got ch%0d d%h exp ch1 dB2", m_ch, m_data); end
    sel = 2'd3; rr_en = 1'b0; drive(1, 8'hB3, 1'b1);
    tick();
    checks++; if (m_ch !== 2'd1 || m_data !== 8'hB3 || m_last !== 1'b1)
      begin errors++; $display("FAIL lock_b3 got ch%0d d%h l%b exp ch1 dB3 l1", m_ch, m_data, m_last); end
    s_valid = 4'b0001; rr_en = 1'b1;
    tick();
    checks++; if (m_ch !== 2'd0 || m_data !== 8'hC0) begin errors++; $display("FAIL lock_after got ch%0d d%h exp ch0 dC0", m_ch, m_data); end
    s_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    reset_pulse();
    rr_en = 1'b0; sel = 2'd0; m_ready = 1'b1;
    s_valid = 4'b0001; drive(0, 8'h5A, 1'b1);
    tick();
    checks++; if (m_data !== 8'h5A) begin errors++; $display("FAIL bp_first got %h exp 5A", m_data); end
    m_ready = 1'b0; drive(0, 8'h6B, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", i, s_ready); end
      tick();
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin errors++; $display("FAIL bp_hold%0d got v%b d%h exp v1 d5A", i, m_valid, m_data); end
    end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL bp_release got %b exp 0001", s_ready); end
    tick();
    checks++; if (m_data !== 8'h6B) begin errors++; $display("FAIL bp_next got %h exp 6B", m_data); end
    s_valid = '0;
    tick();
  endtask

  task automatic test_out_of_range();
    rr_en3 = 1'b0; sel3 = 2'd3; s_valid3 = 3'b111; m_ready3 = 1'b1;
    s_data3 = 24'hC2C1C0; s_last3 = 3'b111;
    #1;
    checks++; if (s_ready3 !== 3'b000) begin errors++; $display("FAIL oor_ready got %b exp 000", s_ready3); end
    tick();
    checks++; if (m_valid3 !== 1'b0) begin errors++; $display("FAIL oor_valid got %b exp 0", m_valid3); end
    sel3 = 2'd1;
    #1;
    checks++; if (s_ready3 !== 3'b010) begin errors++; $display("FAIL oor_inrange got %b exp 010", s_ready3); end
    tick();
    checks++; if (m_valid3 !== 1'b1 || m_ch3 !== 2'd1 || m_data3 !== 8'hC1)
      begin errors++; $display("FAIL oor_beat got v%b ch%0d d%h exp v1 ch1 dC1", m_valid3, m_ch3, m_data3); end
    s_valid3 = '0;
  endtask

  task automatic test_reset_mid_packet();
    reset_pulse();
    rr_en = 1'b0; sel = 2'd2; m_ready = 1'b1;
    s_valid = 4'b0100; drive(2, 8'h77, 1'b0);
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmp_start got %b exp 1", m_valid); end
    rst = 1'b1; s_valid = 4'hF;
    #1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rmp_ready got %b exp 0000", s_ready); end
    tick();
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmp_valid got %b exp 0", m_valid); end
    rr_en = 1'b1; s_last = 4'hF; s_data = 32'h33221100;
    #1;
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL rmp_grant got %b exp 0001", s_ready); end
    tick();
    checks++; if (m_ch !== 2'd0 || m_data !== 8'h00) begin errors++; $display("FAIL rmp_ch got ch%0d d%h exp ch0 d00", m_ch, m_data); end
    s_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int g;
    bit load, acc;
    logic [3:0]  exp_rdy;
    logic [10:0] exp_out;
    reset_pulse();
    rr_en = 1'b0;
    mv = 0; md = 0; ml = 0; mc = 0; locked = -1; last_ptr = N - 1;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      s_valid = 4'($urandom);
      s_data  = $urandom;
      for (int k = 0; k < 4; k++) s_last[k] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) rr_en = 1'($urandom);
      sel = 2'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant(s_valid, sel, rr_en);
      load = (mv == 0) || m_ready;
      exp_rdy = (g >= 0 && load && !rst) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (s_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready%0d got %b exp %b", n, s_ready, exp_rdy); end
      acc = (exp_rdy != 0) && s_valid[g];
      @(posedge clk);
      if (rst) begin
        mv = 0; md = 0; ml = 0; mc = 0; locked = -1; last_ptr = N - 1;
      end else if (load) begin
        mv = acc ? 1 : 0;
        if (acc) begin
          md = int'(s_data[g*8 +: 8]); ml = int'(s_last[g]); mc = g;
          if (s_last[g]) begin locked = -1; last_ptr = g; end
          else locked = g;
        end
      end
      @(negedge clk);
      checks++;
      if (m_valid !== (mv != 0)) begin errors++; $display("FAIL rand_valid%0d got %b exp %0d", n, m_valid, mv); end
      if (mv != 0) begin
        exp_out = {8'(md), 1'(ml), 2'(mc)};
        checks++;
        if ({m_data, m_last, m_ch} !== exp_out)
          begin errors++; $display("FAIL rand_beat%0d got d%h l%b ch%0d exp %h", n, m_data, m_last, m_ch, exp_out); end
      end
    end
    rst = 1'b0; s_valid = '0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; sel = '0; rr_en = 1'b0; m_ready = 1'b1;
    s_valid3 = '0; s_last3 = '0; s_data3 = '0; sel3 = '0; rr_en3 = 1'b0; m_ready3 = 1'b1;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
